// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared defaults and types for the mm_responder memory-model
//            responder: default parameter values, address / operation-ID
//            typedefs and the default-width in-flight slot record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int          C_TAG_WIDTH   = 8;
    localparam int          C_INDEX_WIDTH = 4;
    localparam int          C_DATA_WIDTH  = 16;
    localparam int          C_NUM_OPS     = 32;
    localparam int          C_QUEUE_DEPTH = 4;
    localparam int          C_LATENCY     = 8;
    localparam logic [15:0] C_DATA_SEED   = 16'hA5A5;

    localparam int C_ADDR_WIDTH = C_TAG_WIDTH + C_INDEX_WIDTH;
    localparam int C_OP_WIDTH   = $clog2(C_NUM_OPS);
    // Room for LATENCY-1 plus up to 3 cycles of jitter.
    localparam int C_CNT_WIDTH  = $clog2(C_LATENCY + 3);

    typedef logic [C_ADDR_WIDTH-1:0] addr_t;
    typedef logic [C_OP_WIDTH-1:0]   op_t;

    typedef struct packed {
        logic                   valid;
        addr_t                  addr;
        op_t                    op;
        logic [C_CNT_WIDTH-1:0] cnt;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/mm_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mm_responder_if
// Purpose  : Request / return bus of the memory-model responder.
// Signals  : mm_req            - tag (upper bits) and index (lower bits)
//            mm_req_operation  - operation ID of the request
//            mm_req_valid      - request strobe, no backpressure
//            mm_ret_data       - returned data
//            mm_ret_operation  - operation ID of the returned request
//            mm_ret_valid      - one-cycle return strobe
// Modports : master (requester), slave (responder)
// Revision : 1.0 - initial release
// ============================================================================
interface mm_responder_if
    import mm_pkg::*;
#(
    parameter int TAG_WIDTH   = C_TAG_WIDTH,
    parameter int INDEX_WIDTH = C_INDEX_WIDTH,
    parameter int DATA_WIDTH  = C_DATA_WIDTH,
    parameter int NUM_OPS     = C_NUM_OPS
) ();

    logic [TAG_WIDTH+INDEX_WIDTH-1:0] mm_req;
    logic [$clog2(NUM_OPS)-1:0]       mm_req_operation;
    logic                             mm_req_valid;
    logic [DATA_WIDTH-1:0]            mm_ret_data;
    logic [$clog2(NUM_OPS)-1:0]       mm_ret_operation;
    logic                             mm_ret_valid;

    modport master (
        output mm_req, mm_req_operation, mm_req_valid,
        input  mm_ret_data, mm_ret_operation, mm_ret_valid
    );

    modport slave (
        input  mm_req, mm_req_operation, mm_req_valid,
        output mm_ret_data, mm_ret_operation, mm_ret_valid
    );

endinterface
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Purpose  : 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that
//            supplies 0..3 cycles of latency jitter. Seeded to 8'h01 on
//            reset and advances every cycle. Only built when
//            MM_RESP_RANDOM_LAT_EN is defined.
// Ports    : clk    - clock
//            rst    - asynchronous active-low reset
//            jitter - low two LFSR bits
// Revision : 1.0 - initial release
// ============================================================================
`ifdef MM_RESP_RANDOM_LAT_EN
module lfsr8 (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic [1:0]      jitter
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign jitter = r_lfsr[1:0];

endmodule
`endif
`default_nettype wire

// File: rtl/mm_responder.sv
`default_nettype none
// ============================================================================
// Module   : mm_responder
// Purpose  : Memory-model responder. Accepts one request per cycle into the
//            lowest free slot, counts its latency down, and returns
//            data = address XOR DATA_SEED with the request's operation ID.
//            Lowest eligible slot launches first; a full queue drops the
//            request and sets a sticky overflow flag.
// Ports    : clk           - clock
//            rst           - asynchronous active-low reset
//            bus           - mm_responder_if.slave request/return bus
//            pending_count - number of occupied slots
//            overflow      - sticky dropped-request flag
// Options  : MM_RESP_RANDOM_LAT_EN - add 0..3 cycles LFSR jitter per request
// Revision : 1.0 - initial release
// ============================================================================
module mm_responder
    import mm_pkg::*;
#(
    parameter int                    TAG_WIDTH   = C_TAG_WIDTH,
    parameter int                    INDEX_WIDTH = C_INDEX_WIDTH,
    parameter int                    DATA_WIDTH  = C_DATA_WIDTH,
    parameter int                    NUM_OPS     = C_NUM_OPS,
    parameter int                    QUEUE_DEPTH = C_QUEUE_DEPTH,
    parameter int                    LATENCY     = C_LATENCY,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED   = DATA_WIDTH'(C_DATA_SEED)
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    mm_responder_if.slave                       bus,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]    pending_count,
    output logic                                overflow
);

    localparam int AW = TAG_WIDTH + INDEX_WIDTH;
    localparam int OW = $clog2(NUM_OPS);
    localparam int CW = $clog2(LATENCY + 3);
    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    localparam int IW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [QUEUE_DEPTH-1:0] r_valid;
    logic [AW-1:0]          r_addr [QUEUE_DEPTH];
    logic [OW-1:0]          r_op   [QUEUE_DEPTH];
    logic [CW-1:0]          r_cnt  [QUEUE_DEPTH];

    logic                   r_ret_valid;
    logic [DATA_WIDTH-1:0]  r_ret_data;
    logic [OW-1:0]          r_ret_op;
    logic                   r_overflow;

    logic                   w_launch;
    logic [IW-1:0]          w_launch_idx;
    logic                   w_has_free;
    logic [IW-1:0]          w_free_idx;
    logic                   w_accept;
    logic [CW-1:0]          w_load;
    logic [AW-1:0]          w_launch_addr;
    logic [DATA_WIDTH-1:0]  w_launch_data;
    logic [PW-1:0]          w_count;

    // Counter is loaded with latency-1 so the launch edge lands exactly
    // LATENCY edges after the sampling edge.
`ifdef MM_RESP_RANDOM_LAT_EN
    logic [1:0] w_jitter;

    lfsr8 u_lfsr8 (
        .clk    (clk),
        .rst    (rst),
        .jitter (w_jitter)
    );

    assign w_load = CW'(LATENCY - 1) + CW'(w_jitter);
`else
    assign w_load = CW'(LATENCY - 1);
`endif

    // Launch and free-slot selection; descending scan so the lowest index
    // wins. A slot launching this edge counts as free for the new request.
    always_comb begin
        w_launch     = 1'b0;
        w_launch_idx = '0;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_cnt[i] == '0)) begin
                w_launch     = 1'b1;
                w_launch_idx = IW'(i);
            end
        end
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i] || (w_launch && (w_launch_idx == IW'(i)))) begin
                w_has_free = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    assign w_accept      = bus.mm_req_valid && w_has_free;
    assign w_launch_addr = r_addr[w_launch_idx];

    generate
        if (AW >= DATA_WIDTH) begin : g_data_trunc
            assign w_launch_data = w_launch_addr[DATA_WIDTH-1:0] ^ DATA_SEED;
        end else begin : g_data_ext
            assign w_launch_data = {{(DATA_WIDTH-AW){1'b0}}, w_launch_addr} ^ DATA_SEED;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_addr[i] <= '0;
                r_op[i]   <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (w_accept && (w_free_idx == IW'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= bus.mm_req;
                    r_op[i]    <= bus.mm_req_operation;
                    r_cnt[i]   <= w_load;
                end else if (w_launch && (w_launch_idx == IW'(i))) begin
                    r_valid[i] <= 1'b0;
                end else if (r_valid[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ret_valid <= 1'b0;
            r_ret_data  <= '0;
            r_ret_op    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_ret_valid <= w_launch;
            if (w_launch) begin
                r_ret_data <= w_launch_data;
                r_ret_op   <= r_op[w_launch_idx];
            end
            if (bus.mm_req_valid && !w_has_free) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_count = w_count + PW'(r_valid[i]);
        end
    end

    assign bus.mm_ret_valid     = r_ret_valid;
    assign bus.mm_ret_data      = r_ret_data;
    assign bus.mm_ret_operation = r_ret_op;
    assign pending_count        = w_count;
    assign overflow             = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_responder
// Purpose  : Directed self-checking bench for mm_responder (default build):
//            reset values, single request, back-to-back ordering, overflow,
//            slot reuse on the launch edge and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_responder;
    import mm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] pending_count;
    logic       overflow;
    int         checks   = 0;
    int         failures = 0;

    mm_responder_if bus ();

    mm_responder dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .pending_count (pending_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input addr_t a, input op_t o);
        bus.mm_req_valid     = v;
        bus.mm_req           = a;
        bus.mm_req_operation = o;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    addr_t       t2_addr [4] = '{12'h100, 12'h2AB, 12'h3FF, 12'hFFF};
    logic [15:0] t2_data [4] = '{16'hA4A5, 16'hA70E, 16'hA65A, 16'hAA5A};
    int          max_pend;
    int          nret;

    initial begin
        drive(1'b0, '0, '0);
        rst = 1'b0;
        repeat (2) tick();
        chk("rst_ret_valid", 32'(bus.mm_ret_valid), 0);
        chk("rst_ret_data", 32'(bus.mm_ret_data), 0);
        chk("rst_ret_op", 32'(bus.mm_ret_operation), 0);
        chk("rst_pending", 32'(pending_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b1;

        // Single request on the first edge after reset release.
        drive(1'b1, 12'h012, 5'd5);
        tick();
        drive(1'b0, '0, '0);
        chk("t1_pending", 32'(pending_count), 1);
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("t1_valid_e%0d", e), 32'(bus.mm_ret_valid), 32'(e == 8));
            if (e == 8) begin
                chk("t1_op", 32'(bus.mm_ret_operation), 5);
                chk("t1_data", 32'(bus.mm_ret_data), 32'h0000A5B7);
            end
        end

        // Back-to-back requests return in order.
        max_pend = 0;
        for (int e = 0; e <= 12; e++) begin
            if (e < 4) drive(1'b1, t2_addr[e], op_t'(e + 1));
            else       drive(1'b0, '0, '0);
            tick();
            if (int'(pending_count) > max_pend) max_pend = int'(pending_count);
            chk($sformatf("t2_valid_e%0d", e), 32'(bus.mm_ret_valid), 32'(e >= 8 && e <= 11));
            if (e >= 8 && e <= 11) begin
                chk($sformatf("t2_op_e%0d", e), 32'(bus.mm_ret_operation), 32'(e - 7));
                chk($sformatf("t2_data_e%0d", e), 32'(bus.mm_ret_data), 32'(t2_data[e-8]));
            end
        end
        chk("t2_peak_pending", 32'(max_pend), 4);
        chk("t2_hold_op", 32'(bus.mm_ret_operation), 4);
        chk("t2_hold_data", 32'(bus.mm_ret_data), 32'h0000AA5A);
        chk("t2_drained", 32'(pending_count), 0);

        // Overflow: fifth request on a full queue is dropped.
        nret = 0;
        for (int e = 0; e <= 14; e++) begin
            if (e < 5) drive(1'b1, addr_t'(e + 1), op_t'(10 + e));
            else       drive(1'b0, '0, '0);
            tick();
            if (e == 3) chk("t3_no_ovf_yet", 32'(overflow), 0);
            if (e == 4) begin
                chk("t3_ovf_set", 32'(overflow), 1);
                chk("t3_pending_full", 32'(pending_count), 4);
            end
            if (bus.mm_ret_valid === 1'b1) begin
                chk($sformatf("t3_op_ret%0d", nret), 32'(bus.mm_ret_operation), 32'(10 + nret));
                nret++;
            end
        end
        chk("t3_ret_count", 32'(nret), 4);
        chk("t3_ovf_sticky", 32'(overflow), 1);
        chk("t3_drained", 32'(pending_count), 0);

        // Reset clears the sticky flag.
        rst = 1'b0;
        #1;
        chk("t4_rst_ovf", 32'(overflow), 0);
        tick();
        rst = 1'b1;

        // Slot reuse: request at the edge where slot 0 launches.
        nret = 0;
        for (int e = 0; e <= 17; e++) begin
            if (e < 4)       drive(1'b1, addr_t'(12'h010 + e), op_t'(20 + e));
            else if (e == 8) drive(1'b1, 12'h5A5, 5'd9);
            else             drive(1'b0, '0, '0);
            tick();
            if (e == 8) begin
                chk("t4_pending_reuse", 32'(pending_count), 4);
                chk("t4_no_ovf", 32'(overflow), 0);
            end
            if (bus.mm_ret_valid === 1'b1) nret++;
            if (e == 16) begin
                chk("t4_reuse_valid", 32'(bus.mm_ret_valid), 1);
                chk("t4_reuse_op", 32'(bus.mm_ret_operation), 9);
                chk("t4_reuse_data", 32'(bus.mm_ret_data), 32'h0000A000);
            end
        end
        chk("t4_ret_count", 32'(nret), 5);
        chk("t4_ovf_final", 32'(overflow), 0);

        // Mid-flight reset discards in-flight requests.
        for (int e = 0; e <= 3; e++) begin
            if (e == 0)      drive(1'b1, 12'h0AA, 5'd30);
            else if (e == 1) drive(1'b1, 12'h0BB, 5'd31);
            else             drive(1'b0, '0, '0);
            tick();
        end
        chk("t5_pending_before", 32'(pending_count), 2);
        rst = 1'b0;
        #1;
        chk("t5_ret_valid", 32'(bus.mm_ret_valid), 0);
        chk("t5_ret_data", 32'(bus.mm_ret_data), 0);
        chk("t5_ret_op", 32'(bus.mm_ret_operation), 0);
        chk("t5_pending", 32'(pending_count), 0);
        chk("t5_overflow", 32'(overflow), 0);
        repeat (2) tick();
        rst = 1'b1;
        nret = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (bus.mm_ret_valid === 1'b1) nret++;
        end
        chk("t5_no_returns", 32'(nret), 0);
        chk("t5_pending_after", 32'(pending_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
